// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button synchronise/debounce and IDLE/RUN/PAUSE control for the stopwatch
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       count_enabled,
    output logic       init_regs,
    output logic [1:0] state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_clear, btn_start_stop};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_btn
            logic          r_s1;
            logic          r_s2;
            logic          r_db_level;
            logic          r_press;
            logic [CW-1:0] r_cnt;

            // Level is accepted on the edge that sees the DEBOUNCE_CYCLES-th consecutive mismatch.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1       <= 1'b0;
                    r_s2       <= 1'b0;
                    r_db_level <= 1'b0;
                    r_press    <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_s1    <= w_btn_raw[g];
                    r_s2    <= r_s1;
                    r_press <= 1'b0;
                    if (r_s2 == r_db_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt      <= '0;
                        r_db_level <= r_s2;
                        r_press    <= r_s2;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign w_press[g] = r_press;
        end
    endgenerate

    logic   w_ss;
    logic   w_clr;
    state_t r_state;
    state_t w_state_nxt;
    logic   r_count_en;
    logic   r_init;
    logic   w_init_nxt;

    assign w_ss  = w_press[0];
    assign w_clr = w_press[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count_en <= 1'b0;
            r_init     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_count_en <= (w_state_nxt == ST_RUN);
            r_init     <= w_init_nxt;
        end
    end

    // Clear beats start/stop in IDLE and PAUSE; RUN ignores clear entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_init_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr) begin
                    w_init_nxt = 1'b1;
                end else if (w_ss) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ss) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_init_nxt  = 1'b1;
                end else if (w_ss) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_init_nxt  = 1'b1;
            end
        endcase
    end

    assign state         = r_state;
    assign count_enabled = r_count_en;
    assign init_regs     = r_init;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - randomized and directed check of stopwatch_ctrl against a window-based model
module tb_stopwatch_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       count_enabled;
    logic       init_regs;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    bit cmp_en   = 1'b0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .count_enabled  (count_enabled),
        .init_regs      (init_regs),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Model: a button level is accepted once the last D synchronised samples
    // (raw samples taken 2..D+1 edges ago) all disagree with the accepted level.
    bit         m_hist [2][D+2];
    bit         m_db   [2];
    bit         m_press[2];
    logic [1:0] m_state = 2'b00;
    bit         m_ce    = 1'b0;
    bit         m_init  = 1'b1;
    bit         raw_v  [2];
    bit         all_diff;
    bit         ss_p, clr_p;
    logic [1:0] ns;
    bit         ni;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < D + 2; i++) m_hist[b][i] = 1'b0;
                m_db[b]    = 1'b0;
                m_press[b] = 1'b0;
            end
            m_state = 2'b00;
            m_ce    = 1'b0;
            m_init  = 1'b1;
        end else begin
            raw_v[0] = btn_start_stop;
            raw_v[1] = btn_clear;
            ss_p  = m_press[0];
            clr_p = m_press[1];
            for (int b = 0; b < 2; b++) begin
                for (int i = D + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
                m_hist[b][0] = raw_v[b];
                all_diff = 1'b1;
                for (int i = 2; i <= D + 1; i++)
                    if (m_hist[b][i] == m_db[b]) all_diff = 1'b0;
                m_press[b] = all_diff && !m_db[b];
                if (all_diff) m_db[b] = !m_db[b];
            end
            ns = m_state;
            ni = 1'b0;
            case (m_state)
                2'b00: if (clr_p) ni = 1'b1; else if (ss_p) ns = 2'b01;
                2'b01: if (ss_p) ns = 2'b10;
                2'b10: if (clr_p) begin ns = 2'b00; ni = 1'b1; end
                       else if (ss_p) ns = 2'b01;
                default: begin ns = 2'b00; ni = 1'b1; end
            endcase
            m_state = ns;
            m_init  = ni;
            m_ce    = (ns == 2'b01);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks++;
            if (state !== m_state || count_enabled !== m_ce || init_regs !== m_init) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t act state=%b ce=%b init=%b exp state=%b ce=%b init=%b",
                         $time, state, count_enabled, init_regs, m_state, m_ce, m_init);
            end
            n_checks++;
            if (count_enabled === 1'b1 && init_regs === 1'b1) begin
                n_fail++;
                $display("FAIL ce_init_excl t=%0t act ce=1 init=1 exp not both", $time);
            end
            if (init_regs === 1'b1 && rst_n === 1'b1) pulse_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    task automatic press(input bit ss, input bit clr, input int hold);
        @(negedge clk);
        btn_start_stop = ss;
        btn_clear      = clr;
        repeat (hold) @(negedge clk);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    initial begin
        int p0;
        int cnt0;
        int cnt1;
        cnt0 = 0;
        cnt1 = 0;
        rst_n = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", state, 2'b00);
        chk("rst_ce", count_enabled, 1'b0);
        chk("rst_init", init_regs, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        #1 chk("rel_init_hold", init_regs, 1'b1);
        @(posedge clk);
        #1 chk("rel_init_drop", init_regs, 1'b0);

        // Start latency: 7 edges counting the first sampling edge
        @(negedge clk);
        btn_start_stop = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("lat_before", state, 2'b00);
        @(posedge clk);
        #1 chk("lat_state", state, 2'b01);
        chk("lat_ce", count_enabled, 1'b1);
        repeat (3) @(negedge clk);
        btn_start_stop = 1'b0;
        repeat (D + 4) @(negedge clk);

        press(1, 0, 6); chk("pause", state, 2'b10);
        chk("pause_ce", count_enabled, 1'b0);
        press(1, 0, 6); chk("resume", state, 2'b01);
        p0 = pulse_cnt;
        press(0, 1, 6); chk("clr_in_run", state, 2'b01);
        chk("clr_in_run_pulses", pulse_cnt - p0, 0);
        press(1, 0, 6); chk("pause2", state, 2'b10);
        p0 = pulse_cnt;
        press(0, 1, 6); chk("clr_in_pause", state, 2'b00);
        chk("clr_in_pause_pulses", pulse_cnt - p0, 1);
        press(1, 0, 6); chk("run3", state, 2'b01);
        p0 = pulse_cnt;
        press(1, 1, 6); chk("both_in_run", state, 2'b10);
        chk("both_in_run_pulses", pulse_cnt - p0, 0);
        p0 = pulse_cnt;
        press(1, 1, 6); chk("both_in_pause", state, 2'b00);
        chk("both_in_pause_pulses", pulse_cnt - p0, 1);
        p0 = pulse_cnt;
        press(1, 1, 6); chk("both_in_idle", state, 2'b00);
        chk("both_in_idle_pulses", pulse_cnt - p0, 1);

        // Bounce: 3-cycle pulses never pass a 4-cycle debouncer
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            btn_start_stop = ((i / 3) % 2) == 0;
        end
        chk("bounce_idle", state, 2'b00);
        @(negedge clk);
        btn_start_stop = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("bounce_before", state, 2'b00);
        @(posedge clk);
        #1 chk("bounce_run", state, 2'b01);
        @(negedge clk);
        btn_start_stop = 1'b0;
        repeat (D + 4) @(negedge clk);

        // Reset mid-RUN and mid-debounce
        @(negedge clk);
        btn_clear = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_state", state, 2'b00);
        chk("midrun_rst_ce", count_enabled, 1'b0);
        chk("midrun_rst_init", init_regs, 1'b1);
        btn_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (D + 4) @(negedge clk);

        // Button held through reset release counts as a fresh press
        btn_start_stop = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (D + 5) @(negedge clk);
        chk("held_thru_rst", state, 2'b01);
        btn_start_stop = 1'b0;
        repeat (D + 4) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cnt0 == 0) begin
                btn_start_stop = 1'($urandom_range(0, 1));
                cnt0 = $urandom_range(1, 10);
            end
            cnt0--;
            if (cnt1 == 0) begin
                btn_clear = 1'($urandom_range(0, 1));
                cnt1 = $urandom_range(1, 12);
            end
            cnt1--;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
